// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding the UART transmitter one byte at a time, paced on the
// transmitter's synchronized TxDone level with a per-phase watchdog.
module uart_tx_feeder #(
  parameter int DEPTH         = 16,
  parameter int STROBE_CYCLES = 2,
  parameter int TIMEOUT       = 2_000_000
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     WrEn,
  input  logic [7:0]               WrData,
  input  logic                     ClrErr,
  input  logic                     TxDone,
  output logic [7:0]               TxData,
  output logic                     TxEn,
  output logic                     Full,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Busy,
  output logic                     Overflow,
  output logic                     TxErr
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_STROBE, S_WAIT_DONE, S_WAIT_RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_en_q, tx_en_d;
  logic [SW-1:0]   stb_cnt_q, stb_cnt_d;
  logic [TW-1:0]   wd_cnt_q, wd_cnt_d;
  logic            ovf_q, ovf_d;
  logic            tx_err_q, tx_err_d;
  logic            sync1_q, done_s_q;
  logic [7:0]      mem [DEPTH];

  logic full, empty, push, pop, wd_expired, err_set;

  always_comb begin
    full       = (count_q == (AW+1)'(DEPTH));
    empty      = (count_q == '0);
    // Full is judged before any same-cycle pop, so a write at Full is dropped.
    push       = WrEn && !full;
    pop        = (state_q == S_IDLE) && !empty;
    wd_expired = (TIMEOUT != 0) && (wd_cnt_q == TW'(TIMEOUT - 1));

    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    stb_cnt_d = stb_cnt_q;
    wd_cnt_d  = wd_cnt_q + TW'(1);
    err_set   = 1'b0;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_data_d = mem[rd_ptr_q];
          tx_en_d   = 1'b1;
          stb_cnt_d = '0;
          state_d   = S_STROBE;
        end
      end
      S_STROBE: begin
        if (stb_cnt_q == SW'(STROBE_CYCLES - 1)) begin
          tx_en_d  = 1'b0;
          wd_cnt_d = '0;
          state_d  = S_WAIT_DONE;
        end else begin
          stb_cnt_d = stb_cnt_q + SW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (done_s_q) begin
          wd_cnt_d = '0;
          state_d  = S_WAIT_RELEASE;
        end else if (wd_expired) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT_RELEASE: begin
        // Restarting while TxDone is still high would abort the next frame.
        if (!done_s_q) begin
          state_d = S_IDLE;
        end else if (wd_expired) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ovf_d    = (ovf_q && !ClrErr) || (WrEn && full);
    tx_err_d = (tx_err_q && !ClrErr) || err_set;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      stb_cnt_q <= '0;
      wd_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      tx_err_q  <= 1'b0;
      sync1_q   <= 1'b0;
      done_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      stb_cnt_q <= stb_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      ovf_q     <= ovf_d;
      tx_err_q  <= tx_err_d;
      sync1_q   <= TxDone;
      done_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= WrData;
  end

  assign TxData   = tx_data_q;
  assign TxEn     = tx_en_q;
  assign Full     = full;
  assign Empty    = empty;
  assign Count    = count_q;
  assign Busy     = (state_q != S_IDLE);
  assign Overflow = ovf_q;
  assign TxErr    = tx_err_q;
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte FIFO and sequencer sitting directly upstream of the UART RS-232 transmitter. Accepts bytes from the system side (CPU bus or Bluetooth command logic), buffers them, and presents them one at a time on the transmitter's `TxData`/`TxEn` inputs. Paces itself on the transmitter's `TxDone` level so that back-to-back bytes go out without loss or double-send.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2..256; `AW = log2(DEPTH)`.
- `STROBE_CYCLES`, 2: clocks `TxEn` is held high per byte; minimum 2, so the transmitter's 2-flop edge detector sees the rise.
- `TIMEOUT`, 2_000_000: max clocks to wait for each `TxDone` phase; 0 disables the watchdog.

Ports (clock and reset first):
- `Clk`  in  1: system clock; the only clock.
- `Rst_n`  in  1: synchronous, active-low reset.
- `WrEn`  in  1: push `WrData` this cycle.
- `WrData`  in  8: byte to enqueue.
- `ClrErr`  in  1: clears `Overflow` and `TxErr`.
- `TxDone`  in  1: level from the transmitter, high after its stop bit. Asynchronous to the feeder FSM, so it is synchronized internally.
- `TxData`  out  8: byte presented to the transmitter. Registered, and stable from the strobe until the next load.
- `TxEn`  out  1: start strobe to the transmitter.
- `Full`  out  1: `Count == DEPTH`.
- `Empty`  out  1: `Count == 0`.
- `Count`  out  AW+1: bytes currently stored.
- `Busy`  out  1: FSM not in IDLE.
- `Overflow`  out  1: sticky; a write was dropped.
- `TxErr`  out  1: sticky; watchdog expired.

## Operation
- Storage is a circular FIFO with `rd_ptr`/`wr_ptr` (AW bits, natural wrap at DEPTH) and a separate `Count`.
- Push: `WrEn && !Full` writes `mem[wr_ptr]`, then `wr_ptr++`.
  - `WrEn && Full` drops the byte, leaves pointers unchanged and sets `Overflow`.
  - `Full` is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs that cycle.
- Pop and push in the same cycle: both pointers advance and `Count` is unchanged.
- `TxDone` passes through a 2-flop synchronizer to give `done_s`. All FSM decisions use `done_s`.
- FSM states:
  - IDLE: when `!Empty`, `TxData <= mem[rd_ptr]`, `rd_ptr++`, `Count--`, `TxEn <= 1`, go to STROBE.
  - STROBE: `TxEn` stays high for `STROBE_CYCLES` clocks in total. Then `TxEn <= 0`, go to WAIT_DONE.
  - WAIT_DONE: wait for `done_s == 1`, then go to WAIT_RELEASE.
  - WAIT_RELEASE: wait for `done_s == 0`, then go to IDLE. The transmitter holds `TxDone` high until its next idle tick; starting a new byte before it falls would abort that byte.
- Watchdog: a cycle counter clears on entry to WAIT_DONE and on entry to WAIT_RELEASE. If it reaches `TIMEOUT` (when `TIMEOUT != 0`), set `TxErr` and go to IDLE. The byte counts as consumed and is not retried.
- `ClrErr` clears both sticky flags. If a new error event occurs in the same cycle, set wins.
- `Busy` = state != IDLE.

## Timing
- Reset (`Rst_n` low at a `Clk` edge) gives:
  - state IDLE, pointers 0, `Count` 0, `Empty` 1, `Full` 0;
  - `TxData` 0x00, `TxEn` 0, `Busy` 0, `Overflow` 0, `TxErr` 0;
  - synchronizer flops 0.
- Reset mid-transfer abandons the byte and discards FIFO contents. `mem` contents need no reset.
- Write-to-strobe latency into an empty FIFO:
  - `WrEn` at edge k gives `Empty = 0` after k;
  - `TxEn = 1` and `TxData` valid after edge k+1;
  - `TxEn` falls after edge k+1+`STROBE_CYCLES`.
- `done_s` lags `TxDone` by 2 clocks.
- Next-byte restart: IDLE is reached 1 clock after `done_s` falls, and the next `TxEn` rises 1 clock after that.
- `Count`, `Full`, `Empty` update on the edge of the push/pop. Flags are derived combinationally from `Count`.
- `TxData` changes only on the IDLE→STROBE edge.

## Test plan
- Single byte: reset, then write 0x55 at cycle 10.
  - `TxEn` must be high for exactly 2 clocks starting cycle 12, with `TxData` = 0x55.
  - The transmitter model must see one frame 0-10101010-1.
  - `Busy` must drop 1 clock after synced `TxDone` falls.
- Burst: write 0x01..0x05 on consecutive cycles.
  - `Count` must peak at 4, since the first byte pops immediately.
  - Exactly 5 `TxEn` strobes, in order 0x01..0x05, each after the prior `TxDone` fall.
  - `Empty` = 1 at the end.
- Overflow: with the transmitter stalled (`TxDone` held 0), write 18 bytes with DEPTH=16.
  - One byte is in flight, so 16 are stored.
  - `Full` = 1 and `Overflow` = 1.
  - `ClrErr` must clear `Overflow` while `Full` stays 1.
- Simultaneous push/pop: while `Count` = 3 and the FSM is in IDLE, write on the pop cycle.
  - `Count` must stay 3.
  - Pointer wrap is checked after 40 total bytes with DEPTH=16, and data order is preserved.
- Watchdog: `TIMEOUT` = 100, `TxDone` never rises.
  - `TxErr` = 1 exactly 100 clocks after entering WAIT_DONE.
  - The FSM returns to IDLE, and the next queued byte is strobed.
- Reset mid-operation: assert `Rst_n` = 0 during WAIT_DONE with 3 bytes queued.
  - On the next edge: all outputs at reset values, `Count` = 0, no further `TxEn`.
